sa_sequencer: RTL and testbench
===============================

# sa_sequencer

Job-level controller for the systolic-array data-loading path. It sequences one weight preload followed by N feature-tile loads through the shared single-port RAM. It drives the RAM-port `mode` select and the loader enables, waits out the array drain, and captures the 2×2 result of each tile. It sits between the host/top-level control and the weight preloader, feature loader and systolic array.

## Interface
Parameters:
- `FEATURE_STRIDE`, 9: feature base-address increment per tile (words).
- `DRAIN_CYCLES`, 3: cycles waited after feature-load done before sampling `c11..c22`; legal range 1..15.
- `TIMEOUT`, 255: maximum cycles in a load state before error; legal range 1..255.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset, synchronous, active-low (`rst==0` at a rising edge resets).
- `start`  in  1  job request; sampled only in IDLE.
- `cfg_feature_base`  in  6  first tile base address; sampled with `start`.
- `cfg_tile_cnt`  in  4  number of tiles, 0..15; sampled with `start`.
- `abort`  in  1  synchronous job cancel.
- `is_WL_done_i`  in  1  weight preloader done (level).
- `is_FL_done_i`  in  1  feature loader done (level).
- `c11`, `c12`, `c21`, `c22`  in  8 each  array outputs.
- `Weight_Preloader_en`  out  1  weight loader enable (level).
- `Feature_Loader_en`  out  1  feature loader enable (level).
- `feature_baseaddr`  out  6  current tile base.
- `mode`  out  1  RAM port select: 0 = weight, 1 = feature.
- `result`  out  32  `{c11,c12,c21,c22}` of the last tile.
- `result_valid`  out  1  one-cycle strobe per captured tile.
- `tile_idx`  out  4  index of the tile in `result`.
- `busy`  out  1  job in progress.
- `done`  out  1  one-cycle job-end strobe.
- `error`  out  1  sticky timeout flag; cleared by the next accepted `start`.

## Operation
- All outputs are registered.
- Reset values: all outputs 0. `mode` resets to 0. State resets to IDLE. Internal counters reset to 0.
- **IDLE**
  - `start=1` with `cfg_tile_cnt≠0`: latch config, clear `error`, go to W_SETUP.
  - `start=1` with `cfg_tile_cnt=0`: go to FINISH. No loader is enabled.
- **W_SETUP** (1 cycle): `mode=0`, both enables 0, `busy=1`.
- **W_LOAD**: `Weight_Preloader_en=1`.
  - `is_WL_done_i=1` goes to SWITCH.
- **SWITCH** (1 cycle): enables 0, `mode=1`.
  - This gap is mandatory because read-data steering lags `mode` by one cycle.
- **F_LOAD**: `Feature_Loader_en=1`, `feature_baseaddr`=current base.
  - `is_FL_done_i=1` goes to DRAIN.
- **DRAIN**: enables 0, counts `DRAIN_CYCLES` cycles, then goes to CAPTURE.
- **CAPTURE** (1 cycle):
  - Latch `result` and `tile_idx`. Pulse `result_valid` in the next cycle.
  - Increment the tile counter. Next base = base + `FEATURE_STRIDE` mod 64 (6-bit wrap).
  - Tiles remaining: go to F_GAP. Otherwise go to FINISH.
- **F_GAP** (1 cycle): enables 0, `mode` stays 1, new base driven; then F_LOAD. The gap lets the loader re-arm.
- **FINISH** (1 cycle): `done=1`, `busy=0`; then IDLE. `mode` holds its last value in IDLE.
- **ERROR**: entered when the timeout counter reaches `TIMEOUT` in W_LOAD or F_LOAD before the matching done.
  - Enables 0, `error=1`, then FINISH.
- Timeout counter: cleared on every entry to W_LOAD or F_LOAD; 8 bits, saturating.
- Done inputs are acted on only in their own load state. A done seen in any other state is ignored.
- `abort=1` in any non-IDLE state: next cycle state is IDLE, enables 0, `busy=0`, no `done`, no `result_valid`. `error` is unchanged.
- Priority: `rst` > `abort` > timeout > done input.
- `start` while not IDLE is ignored. Config changes mid-job are ignored.

## Timing
- `start` sampled at cycle t:
  - t+1: `busy=1`, `mode=0`.
  - t+2: `Weight_Preloader_en=1`.
- `is_WL_done_i` first high at cycle d:
  - d+1: `Weight_Preloader_en=0`, `mode=1`.
  - d+2: `Feature_Loader_en=1`.
- `is_FL_done_i` first high at cycle f:
  - f+1: `Feature_Loader_en=0`.
  - CAPTURE at f+1+`DRAIN_CYCLES`. `c**` are sampled in that cycle.
  - `result_valid` at f+2+`DRAIN_CYCLES`.
- Between tiles: CAPTURE at c, F_GAP at c+1, `Feature_Loader_en=1` again at c+2.
- `done` is asserted the cycle after the last CAPTURE, or t+1 when `cfg_tile_cnt=0`.
- Timeout: ERROR is entered the cycle after the counter hits `TIMEOUT`; `done` follows one cycle later.
- Invariant: `Weight_Preloader_en` and `Feature_Loader_en` are never both 1.
- Invariant: `mode` never changes in a cycle where an enable is 1.

## Test plan
- Reset: drive `rst=0` with `start=1` for 2 cycles -> all outputs 0; the job starts only after `rst=1`.
- Single tile, `cfg_feature_base=6'd10`, `cfg_tile_cnt=1`, WL done 5 cycles after enable, FL done 7 cycles after enable, `c11..c22`=1,2,3,4 -> `result`=32'h01020304, `tile_idx`=0, one `result_valid`, then `done`. Enable and `mode` edges match the Timing section exactly.
- Three tiles, base 60, stride 9 -> `feature_baseaddr` sequence 60, 5, 14 (wrap); three `result_valid` with `tile_idx` 0, 1, 2; weights loaded once.
- `cfg_tile_cnt=0` -> `done` at t+1, no enable ever high, `busy` stays 0.
- Hold `is_FL_done_i=0` with `TIMEOUT=20` -> `Feature_Loader_en` drops after 20 cycles, `error=1`, `done` pulses. The next `start` clears `error`.
- `abort` during F_LOAD of tile 1 -> next cycle IDLE, enables 0, no `done`. `start` raised mid-job is ignored. Spurious `is_WL_done_i` during F_LOAD has no effect.

Source files
------------

// File: rtl/sa_sequencer.sv
// ---------------------------------------------------------------------------
// sa_sequencer
//
// Job-level controller for the systolic-array data-loading path. A job is one
// weight preload followed by N feature-tile loads. All of them go through the
// shared single-port RAM. For each tile the sequencer:
//   - steers the RAM port with `mode`,
//   - enables the matching loader,
//   - waits out the array drain,
//   - captures the 2x2 result.
//
// Loader handshake: an enable is a level held high for the whole load state.
// The loader answers with a level `done`. A done input is acted on only while
// the sequencer sits in that loader's own load state. At any other time it is
// ignored.
//
// Ports
//   clk                 sole clock, rising edge
//   rst                 synchronous reset, active low
//   start               job request, sampled only in IDLE
//   cfg_feature_base    first tile base address, sampled with start
//   cfg_tile_cnt        number of tiles (0..15), sampled with start
//   abort               synchronous job cancel (any non-IDLE state)
//   is_WL_done_i        weight preloader done (level)
//   is_FL_done_i        feature loader done (level)
//   c11..c22            systolic array outputs
//   Weight_Preloader_en weight loader enable
//   Feature_Loader_en   feature loader enable
//   feature_baseaddr    current tile base address
//   mode                RAM port select: 0 = weight, 1 = feature
//   result              {c11,c12,c21,c22} of the last captured tile
//   result_valid        one-cycle strobe per captured tile
//   tile_idx            index of the tile held in result
//   busy                job in progress
//   done                one-cycle job-end strobe
//   error               sticky timeout flag, cleared by the next accepted start
//   o_dbg_state         current FSM state, for observation only
// ---------------------------------------------------------------------------
module sa_sequencer #(
  parameter int FEATURE_STRIDE = 9,
  parameter int DRAIN_CYCLES   = 3,   // 1..15
  parameter int TIMEOUT        = 255  // 1..255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [5:0]  cfg_feature_base,
  input  logic [3:0]  cfg_tile_cnt,
  input  logic        abort,
  input  logic        is_WL_done_i,
  input  logic        is_FL_done_i,
  input  logic [7:0]  c11,
  input  logic [7:0]  c12,
  input  logic [7:0]  c21,
  input  logic [7:0]  c22,
  output logic        Weight_Preloader_en,
  output logic        Feature_Loader_en,
  output logic [5:0]  feature_baseaddr,
  output logic        mode,
  output logic [31:0] result,
  output logic        result_valid,
  output logic [3:0]  tile_idx,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [3:0]  o_dbg_state
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_W_SETUP = 4'd1,
    S_W_LOAD  = 4'd2,
    S_SWITCH  = 4'd3,
    S_F_LOAD  = 4'd4,
    S_DRAIN   = 4'd5,
    S_CAPTURE = 4'd6,
    S_F_GAP   = 4'd7,
    S_FINISH  = 4'd8,
    S_ERROR   = 4'd9
  } state_t;

  // The timeout fires on the last permitted cycle of a load state. As a
  // result, an enable stays high for exactly TIMEOUT cycles before it drops.
  localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT - 1);
  localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_CYCLES - 1);
  localparam logic [5:0] STRIDE     = 6'(FEATURE_STRIDE % 64);

  state_t      r_state;
  state_t      w_next_state;

  // Latched job configuration and per-job counters
  logic [5:0]  r_base;
  logic [3:0]  r_tile_cnt;
  logic [3:0]  r_tile;
  logic [7:0]  r_tmo;
  logic [3:0]  r_drain;

  // Output registers
  logic        r_wl_en;
  logic        r_fl_en;
  logic        r_mode;
  logic [31:0] r_result;
  logic        r_result_valid;
  logic [3:0]  r_tile_idx;
  logic        r_busy;
  logic        r_done;
  logic        r_error;

  // Next values for the output registers, decoded from the next state
  logic        w_wl_en_nxt;
  logic        w_fl_en_nxt;
  logic        w_mode_nxt;
  logic        w_busy_nxt;
  logic        w_done_nxt;
  logic        w_error_nxt;
  logic        w_rv_nxt;

  logic        w_accept;
  logic        w_timeout;
  logic        w_more_tiles;
  logic        w_capture;

  assign w_accept     = (r_state == S_IDLE) && start;
  assign w_timeout    = (r_tmo == TMO_LAST);
  // Compare in 5 bits so that a count of 15 cannot wrap.
  assign w_more_tiles = ({1'b0, r_tile} + 5'd1) < {1'b0, r_tile_cnt};
  // A CAPTURE cycle cut short by abort produces no result.
  assign w_capture    = (r_state == S_CAPTURE) && !abort;

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic. Priority is abort > timeout > done input.
  // -------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next_state = (cfg_tile_cnt == 4'd0) ? S_FINISH : S_W_SETUP;
        end
      end
      S_W_SETUP: w_next_state = S_W_LOAD;
      S_W_LOAD: begin
        if (w_timeout) begin
          w_next_state = S_ERROR;
        end else if (is_WL_done_i) begin
          w_next_state = S_SWITCH;
        end
      end
      // Read-data steering lags mode by one cycle. This state lets the new
      // mode settle before the feature loader starts.
      S_SWITCH: w_next_state = S_F_LOAD;
      S_F_LOAD: begin
        if (w_timeout) begin
          w_next_state = S_ERROR;
        end else if (is_FL_done_i) begin
          w_next_state = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (r_drain == DRAIN_LAST) begin
          w_next_state = S_CAPTURE;
        end
      end
      S_CAPTURE: w_next_state = w_more_tiles ? S_F_GAP : S_FINISH;
      // One idle cycle so the feature loader can re-arm on the new base.
      S_F_GAP:   w_next_state = S_F_LOAD;
      S_ERROR:   w_next_state = S_FINISH;
      S_FINISH:  w_next_state = S_IDLE;
      default:   w_next_state = S_IDLE;
    endcase
    if (abort && (r_state != S_IDLE)) begin
      w_next_state = S_IDLE;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: output decode. These values are decoded from the next state and
  // registered below, so each registered output matches the state it
  // accompanies.
  // -------------------------------------------------------------------------
  always_comb begin
    w_wl_en_nxt = (w_next_state == S_W_LOAD);
    w_fl_en_nxt = (w_next_state == S_F_LOAD);
    w_busy_nxt  = (w_next_state != S_IDLE) && (w_next_state != S_FINISH);
    w_done_nxt  = (w_next_state == S_FINISH);
    w_rv_nxt    = w_capture;

    // mode changes only on entry to W_SETUP or SWITCH. Both of those states
    // have their enables low. At all other times mode holds its value,
    // including through IDLE.
    w_mode_nxt = r_mode;
    if (w_next_state == S_W_SETUP) begin
      w_mode_nxt = 1'b0;
    end else if (w_next_state == S_SWITCH) begin
      w_mode_nxt = 1'b1;
    end

    w_error_nxt = r_error;
    if (w_accept) begin
      w_error_nxt = 1'b0;
    end
    if (w_next_state == S_ERROR) begin
      w_error_nxt = 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Output registers, configuration latch and counters
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wl_en        <= 1'b0;
      r_fl_en        <= 1'b0;
      r_mode         <= 1'b0;
      r_result       <= 32'd0;
      r_result_valid <= 1'b0;
      r_tile_idx     <= 4'd0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_error        <= 1'b0;
      r_base         <= 6'd0;
      r_tile_cnt     <= 4'd0;
      r_tile         <= 4'd0;
      r_tmo          <= 8'd0;
      r_drain        <= 4'd0;
    end else begin
      r_wl_en        <= w_wl_en_nxt;
      r_fl_en        <= w_fl_en_nxt;
      r_mode         <= w_mode_nxt;
      r_result_valid <= w_rv_nxt;
      r_busy         <= w_busy_nxt;
      r_done         <= w_done_nxt;
      r_error        <= w_error_nxt;

      if (w_accept) begin
        r_base     <= cfg_feature_base;
        r_tile_cnt <= cfg_tile_cnt;
        r_tile     <= 4'd0;
      end else if (w_capture) begin
        r_result   <= {c11, c12, c21, c22};
        r_tile_idx <= r_tile;
        r_tile     <= r_tile + 4'd1;
        r_base     <= r_base + STRIDE;  // 6-bit address wraps naturally
      end

      // Timeout counter: restarts on every state change, which includes
      // each entry to W_LOAD or F_LOAD. It saturates at 255.
      if (w_next_state != r_state) begin
        r_tmo <= 8'd0;
      end else if (r_tmo != 8'hFF) begin
        r_tmo <= r_tmo + 8'd1;
      end

      if ((r_state == S_DRAIN) && (w_next_state == S_DRAIN)) begin
        r_drain <= r_drain + 4'd1;
      end else begin
        r_drain <= 4'd0;
      end
    end
  end

  assign Weight_Preloader_en = r_wl_en;
  assign Feature_Loader_en   = r_fl_en;
  assign feature_baseaddr    = r_base;
  assign mode                = r_mode;
  assign result              = r_result;
  assign result_valid        = r_result_valid;
  assign tile_idx            = r_tile_idx;
  assign busy                = r_busy;
  assign done                = r_done;
  assign error               = r_error;
  assign o_dbg_state         = r_state;

endmodule

// File: tb/tb_sa_sequencer.sv
// ---------------------------------------------------------------------------
// tb_sa_sequencer
//
// Directed bench for sa_sequencer. It uses DRAIN_CYCLES=3, FEATURE_STRIDE=9
// and TIMEOUT=20. Inputs are driven 1 ns after a rising edge, so each DUT
// output is inspected in the cycle it belongs to. Expected tile results are
// queued in exp_q and popped on each result_valid strobe.
// ---------------------------------------------------------------------------
module tb_sa_sequencer;

  localparam int DRAIN  = 3;
  localparam int STRIDE = 9;
  localparam int TMO    = 20;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start;
  logic [5:0]  cfg_base;
  logic [3:0]  cfg_cnt;
  logic        abort;
  logic        wl_done;
  logic        fl_done;
  logic [7:0]  c11, c12, c21, c22;

  logic        wl_en;
  logic        fl_en;
  logic [5:0]  feature_baseaddr;
  logic        mode;
  logic [31:0] result;
  logic        result_valid;
  logic [3:0]  tile_idx;
  logic        busy;
  logic        done;
  logic        error;
  logic [3:0]  dbg_state;

  sa_sequencer #(
    .FEATURE_STRIDE(STRIDE),
    .DRAIN_CYCLES  (DRAIN),
    .TIMEOUT       (TMO)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .start              (start),
    .cfg_feature_base   (cfg_base),
    .cfg_tile_cnt       (cfg_cnt),
    .abort              (abort),
    .is_WL_done_i       (wl_done),
    .is_FL_done_i       (fl_done),
    .c11                (c11),
    .c12                (c12),
    .c21                (c21),
    .c22                (c22),
    .Weight_Preloader_en(wl_en),
    .Feature_Loader_en  (fl_en),
    .feature_baseaddr   (feature_baseaddr),
    .mode               (mode),
    .result             (result),
    .result_valid       (result_valid),
    .tile_idx           (tile_idx),
    .busy               (busy),
    .done               (done),
    .error              (error),
    .o_dbg_state        (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int          n_total = 0;
  int          n_bad   = 0;
  logic [31:0] exp_q[$];
  int          wl_rise  = 0;
  int          fl_rise  = 0;
  int          done_cnt = 0;
  logic        prev_wl   = 1'b0;
  logic        prev_fl   = 1'b0;
  logic        prev_mode = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Invariants, result scoreboard and edge counters, evaluated mid-cycle
  always @(negedge clk) begin
    if (rst) begin
      check("en_exclusive", 32'(wl_en & fl_en), 32'd0);
      if (mode !== prev_mode) check("mode_change_with_en", 32'(wl_en | fl_en), 32'd0);
      if (result_valid) begin
        check("rv_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) check("result", result, exp_q.pop_front());
      end
      if (wl_en && !prev_wl) wl_rise++;
      if (fl_en && !prev_fl) fl_rise++;
      if (done) done_cnt++;
    end
    prev_wl   = wl_en;
    prev_fl   = fl_en;
    prev_mode = mode;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Start a job and run the weight phase. The task returns in the first
  // F_LOAD cycle.
  task automatic w_phase(input logic [5:0] base, input logic [3:0] cnt, input int wl_lat);
    start = 1'b1; cfg_base = base; cfg_cnt = cnt;
    tick();                                  // t+1
    start = 1'b0;
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_mode", 32'(mode), 32'd0);
    check("t1_wl_en", 32'(wl_en), 32'd0);
    check("t1_error", 32'(error), 32'd0);
    tick();                                  // t+2
    check("t2_wl_en", 32'(wl_en), 32'd1);
    check("t2_fl_en", 32'(fl_en), 32'd0);
    tick_n(wl_lat);                          // d
    check("d_wl_en", 32'(wl_en), 32'd1);
    wl_done = 1'b1;
    tick();                                  // d+1
    wl_done = 1'b0;
    check("d1_wl_en", 32'(wl_en), 32'd0);
    check("d1_mode", 32'(mode), 32'd1);
    check("d1_fl_en", 32'(fl_en), 32'd0);
    tick();                                  // d+2
    check("d2_fl_en", 32'(fl_en), 32'd1);
  endtask

  // Run one tile starting in its first F_LOAD cycle. A non-last tile ends in
  // the next tile's first F_LOAD cycle. The last tile ends in the FINISH cycle.
  task automatic f_phase(input logic [5:0] exp_base, input logic [31:0] cvals,
                         input int fl_lat, input logic last, input logic [3:0] exp_idx);
    logic [5:0] nb;
    nb = exp_base + 6'(STRIDE);
    check("f_fl_en", 32'(fl_en), 32'd1);
    check("f_base", 32'(feature_baseaddr), 32'(exp_base));
    check("f_mode", 32'(mode), 32'd1);
    tick_n(fl_lat);                          // f
    check("f_fl_held", 32'(fl_en), 32'd1);
    fl_done = 1'b1;
    {c11, c12, c21, c22} = cvals;
    exp_q.push_back(cvals);
    tick();                                  // f+1
    fl_done = 1'b0;
    check("f1_fl_en", 32'(fl_en), 32'd0);
    tick_n(DRAIN);                           // f+1+DRAIN : CAPTURE
    check("cap_rv", 32'(result_valid), 32'd0);
    tick();                                  // f+2+DRAIN
    check("rv_strobe", 32'(result_valid), 32'd1);
    check("rv_tile_idx", 32'(tile_idx), 32'(exp_idx));
    check("rv_done", 32'(done), 32'(last));
    if (!last) begin
      check("gap_fl_en", 32'(fl_en), 32'd0);
      check("gap_mode", 32'(mode), 32'd1);
      check("gap_base", 32'(feature_baseaddr), 32'(nb));
      tick();                                // c+2
    end else begin
      check("fin_busy", 32'(busy), 32'd0);
    end
  endtask

  // ---------------- stimulus ----------------
  int d0, w0, f0;

  initial begin
    rst = 1'b0; start = 1'b1; cfg_base = 6'd10; cfg_cnt = 4'd1; abort = 1'b0;
    wl_done = 1'b0; fl_done = 1'b0;
    c11 = 8'd0; c12 = 8'd0; c21 = 8'd0; c22 = 8'd0;

    // Reset held with start high: every output stays at zero
    tick_n(2);
    check("rst_outs", 32'({wl_en, fl_en, feature_baseaddr, mode, result_valid,
                           tile_idx, busy, done, error}), 32'd0);
    check("rst_result", result, 32'd0);
    rst = 1'b1;
    tick();
    check("post_rst_busy", 32'(busy), 32'd1);
    start = 1'b0; abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_setup_busy", 32'(busy), 32'd0);
    check("abort_setup_done", 32'(done), 32'd0);
    tick();

    // Single tile: base 10, WL 5 cycles, FL 7 cycles
    d0 = done_cnt; w0 = wl_rise;
    w_phase(6'd10, 4'd1, 5);
    f_phase(6'd10, 32'h01020304, 7, 1'b1, 4'd0);
    tick();
    check("single_done_off", 32'(done), 32'd0);
    check("single_mode_hold", 32'(mode), 32'd1);
    check("single_done_cnt", 32'(done_cnt - d0), 32'd1);
    check("single_wl_rise", 32'(wl_rise - w0), 32'd1);

    // Three tiles with address wrap: 60, 5, 14
    w0 = wl_rise;
    w_phase(6'd60, 4'd3, 2);
    f_phase(6'd60, 32'h11223344, 3, 1'b0, 4'd0);
    f_phase(6'd5,  32'hA0B0C0D0, 4, 1'b0, 4'd1);
    f_phase(6'd14, 32'h55667788, 1, 1'b1, 4'd2);
    tick();
    check("three_wl_once", 32'(wl_rise - w0), 32'd1);
    check("three_q_empty", 32'(exp_q.size()), 32'd0);

    // Zero tiles: done at t+1, no enables, not busy
    d0 = done_cnt; w0 = wl_rise; f0 = fl_rise;
    start = 1'b1; cfg_cnt = 4'd0; cfg_base = 6'd33;
    tick();
    start = 1'b0;
    check("zero_done", 32'(done), 32'd1);
    check("zero_busy", 32'(busy), 32'd0);
    tick();
    check("zero_done_off", 32'(done), 32'd0);
    check("zero_busy_off", 32'(busy), 32'd0);
    tick();
    check("zero_no_wl", 32'(wl_rise - w0), 32'd0);
    check("zero_no_fl", 32'(fl_rise - f0), 32'd0);
    check("zero_done_cnt", 32'(done_cnt - d0), 32'd1);

    // Timeout in F_LOAD: enable high for TMO cycles, then ERROR, then FINISH
    w_phase(6'd20, 4'd1, 3);
    tick_n(TMO - 1);
    check("tmo_fl_last", 32'(fl_en), 32'd1);
    check("tmo_err_pre", 32'(error), 32'd0);
    tick();
    check("tmo_fl_drop", 32'(fl_en), 32'd0);
    check("tmo_error", 32'(error), 32'd1);
    check("tmo_no_done_yet", 32'(done), 32'd0);
    tick();
    check("tmo_done", 32'(done), 32'd1);
    check("tmo_error_fin", 32'(error), 32'd1);
    tick();
    check("tmo_error_sticky", 32'(error), 32'd1);
    check("tmo_done_off", 32'(done), 32'd0);

    // The next start clears error (checked inside w_phase). This job is then
    // aborted in tile 1.
    w_phase(6'd0, 4'd2, 4);
    start = 1'b1; cfg_cnt = 4'd0; cfg_base = 6'd63; wl_done = 1'b1;
    tick();
    start = 1'b0; wl_done = 1'b0;
    check("spur_fl_en", 32'(fl_en), 32'd1);
    check("spur_mode", 32'(mode), 32'd1);
    check("spur_busy", 32'(busy), 32'd1);
    f_phase(6'd0, 32'hDEADBEEF, 3, 1'b0, 4'd0);
    check("t1_base", 32'(feature_baseaddr), 32'd9);
    check("t1_fl_en", 32'(fl_en), 32'd1);
    tick();
    d0 = done_cnt;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_fl_en", 32'(fl_en), 32'd0);
    check("abort_wl_en", 32'(wl_en), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_error", 32'(error), 32'd0);
    tick_n(3);
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);
    check("abort_idle_busy", 32'(busy), 32'd0);
    check("final_q_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
